// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one fixed-latency sprite ROM among several
// requesters. Grants are combinational from req and the priority pointer;
// the owner of each read rides a ROM_LAT-deep tag pipeline so the returned
// word can be steered back with a one-hot rd_valid.
module sprite_rom_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 4,
    parameter int ROM_LAT = 2
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [ADDR_W-1:0]         rom_addr,
    output logic                      rom_rd,
    input  logic [DATA_W-1:0]         rom_data,
    output logic [NUM_REQ-1:0]        rd_valid,
    output logic [DATA_W-1:0]         rd_data,
    input  logic                      frame_start
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   ptr_next;
    logic [PTR_W-1:0]   win;
    logic [PTR_W-1:0]   idx;
    logic               found;
    logic [ADDR_W-1:0]  slot_addr [NUM_REQ];
    logic [ROM_LAT-1:0] pipe_vld;
    logic [NUM_REQ-1:0] pipe_id   [ROM_LAT];

    // Unpack the flat address bus into one entry per requester.
    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            slot_addr[i] = req_addr[i*ADDR_W +: ADDR_W];
        end
    end

    // Scan requesters starting at ptr, wrapping; first active one wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            idx = PTR_W'((32'(ptr) + off) % NUM_REQ);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        if (Reset) begin
            found = 1'b0;
        end
    end

    // Drive grant, ROM strobe and address for the winner; next pointer follows it.
    always_comb begin
        gnt      = '0;
        gnt[win] = found;
        rom_rd   = found;
        rom_addr = found ? slot_addr[win] : '0;
        ptr_next = (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
    end

    // Priority pointer: reset and frame start both return it to requester 0.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            ptr <= '0;
        end else if (frame_start) begin
            ptr <= '0;
        end else if (found) begin
            ptr <= ptr_next;
        end
    end

    // Valid bits of the owner pipeline; reset discards reads in flight.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pipe_vld <= '0;
        end else begin
            pipe_vld[0] <= rom_rd;
            for (int unsigned i = 1; i < ROM_LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
            end
        end
    end

    // Owner one-hot ids shift alongside the valid bits; no reset needed.
    always_ff @(posedge Clk) begin
        pipe_id[0] <= gnt;
        for (int unsigned i = 1; i < ROM_LAT; i++) begin
            pipe_id[i] <= pipe_id[i-1];
        end
    end

    assign rd_valid = pipe_id[ROM_LAT-1] & {NUM_REQ{pipe_vld[ROM_LAT-1]}};
    assign rd_data  = rom_data;

endmodule

// File: doc/sprite_rom_arbiter.md
SPRITE_ROM_ARBITER -- requirements
Module: sprite_rom_arbiter

Interface
REQ-001 Parameter NUM_REQ, 4, number of sprite requesters (0 Mario, 1 Goomba, 2 mushroom, 3 Peach).
REQ-002 Parameter ADDR_W, 12, sprite ROM address width.
REQ-003 Parameter DATA_W, 4, sprite ROM word width (palette index).
REQ-004 Parameter ROM_LAT, 2, fixed cycles from rom_rd to valid rom_data (registered-address, registered-output block ROM).
REQ-005 Clk  input  1  single clock; all logic on rising edge.
REQ-006 Reset  input  1  synchronous, active-high reset.
REQ-007 req  input  NUM_REQ  per-requester read request, level, held until granted.
REQ-008 req_addr  input  NUM_REQ*ADDR_W  per-requester address, slot i at bits [i*ADDR_W +: ADDR_W], valid while req[i] high.
REQ-009 gnt  output  NUM_REQ  one-hot grant pulse, one cycle per accepted request.
REQ-010 rom_addr  output  ADDR_W  address to shared sprite ROM.
REQ-011 rom_rd  output  1  ROM read strobe, high in the cycle rom_addr is valid.
REQ-012 rom_data  input  DATA_W  ROM read data, valid ROM_LAT cycles after rom_rd.
REQ-013 rd_valid  output  NUM_REQ  one-hot, marks owner of rd_data this cycle.
REQ-014 rd_data  output  DATA_W  returned ROM word, shared by all requesters.
REQ-015 frame_start  input  1  one-cycle pulse at start of frame; resets arbitration priority.

Function
REQ-016 Arbitration SHALL be round-robin over req using priority pointer ptr (range 0..NUM_REQ-1); highest priority is ptr, then ptr+1 ... wrapping mod NUM_REQ.
REQ-017 Grant SHALL be combinational from req and registered ptr: gnt, rom_addr = req_addr slot of winner, rom_rd = 1 in the same cycle.
REQ-018 At most one gnt bit SHALL be high per cycle; gnt SHALL be all-zero and rom_rd 0 when req is all-zero.
REQ-019 On a grant to index k, ptr SHALL become (k+1) mod NUM_REQ at the next edge; with no grant ptr SHALL hold.
REQ-020 Throughput SHALL be one grant per cycle; a single continuously requesting source SHALL be granted every cycle.
REQ-021 Requester protocol: requester SHALL observe gnt[i] and deassert or advance req_addr in the next cycle; a held req after gnt is a new request.
REQ-022 Owner ID of each grant SHALL travel through a ROM_LAT-deep shift pipeline of {valid, one-hot id}.
REQ-023 rd_valid SHALL equal pipeline tail one-hot id ANDed with its valid bit; rd_data SHALL equal rom_data passed through unregistered.
REQ-024 rd_valid[k] SHALL assert exactly ROM_LAT cycles after gnt[k], for exactly one cycle per grant, in grant order.
REQ-025 rd_data SHALL be don't-care when rd_valid is zero; bench SHALL not check it then.
REQ-026 frame_start SHALL force ptr to 0 at the next edge, overriding REQ-019 when coincident with a grant; in-flight pipeline entries SHALL be unaffected.
REQ-027 Grant in the frame_start cycle SHALL still use the pre-reset ptr.
REQ-028 Change of req_addr of an ungranted requester SHALL have no effect on state.

Reset
REQ-029 While Reset is high at a rising edge: ptr SHALL become 0 and all pipeline valid bits 0.
REQ-030 gnt, rom_rd SHALL be forced 0 while Reset is high regardless of req.
REQ-031 rd_valid SHALL be 0 in the first cycle after Reset and until a post-reset grant has aged ROM_LAT cycles; pre-reset in-flight reads SHALL be discarded.
REQ-032 Reset SHALL take priority over frame_start.

Verification
REQ-033 Reset, req=0000 for 10 cycles -> gnt=0000, rom_rd=0, rd_valid=0000 throughout.
REQ-034 req=1111 held, addrs 0x010/0x020/0x030/0x040 -> gnt 0001,0010,0100,1000,0001 on consecutive cycles; rom_addr 0x010,0x020,0x030,0x040; rd_valid same sequence delayed 2 cycles with ROM model data matching addresses.
REQ-035 Only req[1]=1 held 5 cycles -> gnt=0010 every cycle, 5 rd_valid[1] pulses starting 2 cycles after first grant.
REQ-036 After grant to 2 (ptr=3), pulse frame_start with req=1001 in the same cycle -> gnt=1000 that cycle, next cycle gnt=0001 (ptr=0).
REQ-037 Grants on cycles N, N+1, assert Reset at N+1 -> gnt=0000 in cycle N+1, no rd_valid at N+2 or N+3, ptr=0 after reset.
REQ-038 req=0101 held, ptr=1 -> gnt 0100 then 0001 alternating; no grant to 0010 or 1000.
